// File: rtl/vxe_vpu_stor_eu.sv
// ---------------------------------------------------------------------------
// vxe_vpu_stor_eu
//
// Store execution unit of the VxE vector processing unit. On a one-cycle
// start strobe it snapshots the thread enable mask. It then walks the enabled
// threads from lowest to highest index. For each thread it reads the result
// and destination word address from the thread register file and issues one
// 32-bit write request.
//
// Per-thread sequence (no back-pressure): RD -> CAP -> WR, 3 cycles/thread.
// An empty mask passes through NOP so busy is still seen for one cycle.
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   i_start          start strobe, honoured only when idle
//   i_th_en[7:0]     thread enable mask, sampled with an accepted start
//   o_busy           operation in progress (registered)
//   o_rd_req         thread register file read request (RD state)
//   o_rd_th[2:0]     thread being read
//   i_rd_data[31:0]  read result, valid the cycle after o_rd_req
//   i_rd_addr[37:0]  destination word address, valid with i_rd_data
//   o_wr_valid       write request valid (WR state)
//   o_wr_addr[37:0]  write word address, stable while waiting for i_wr_rdy
//   o_wr_data[31:0]  write data, stable while waiting for i_wr_rdy
//   i_wr_rdy         write accepted when high with o_wr_valid
//   o_th_done[7:0]   one-cycle per-thread "stored" pulse, one-hot or zero
// ---------------------------------------------------------------------------
module vxe_vpu_stor_eu (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_start,
  output logic        o_busy,
  input  logic [7:0]  i_th_en,
  output logic        o_rd_req,
  output logic [2:0]  o_rd_th,
  input  logic [31:0] i_rd_data,
  input  logic [37:0] i_rd_addr,
  output logic        o_wr_valid,
  output logic [37:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  input  logic        i_wr_rdy,
  output logic [7:0]  o_th_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_NOP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rm_q, rm_d;            // threads still to be stored
  logic [2:0]  cur_q, cur_d;          // thread currently in flight
  logic        busy_q, busy_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_valid_q, wr_valid_d;
  logic [37:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [7:0]  th_done_q, th_done_d;
  logic [7:0]  cur_onehot;

  // Index of the lowest set bit; ascending service order falls out of this.
  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        idx = i[2:0];
      end
    end
    return idx;
  endfunction

  assign cur_onehot = 8'b0000_0001 << cur_q;

  always_comb begin
    state_d    = state_q;
    rm_d       = rm_q;
    cur_d      = cur_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    th_done_d  = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          rm_d    = i_th_en;
          state_d = (i_th_en != 8'h00) ? ST_RD : ST_NOP;
        end
      end
      ST_NOP: begin
        state_d = ST_IDLE;
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // Read data arrives the cycle after the request, i.e. now.
        wr_addr_d = i_rd_addr;
        wr_data_d = i_rd_data;
        state_d   = ST_WR;
      end
      ST_WR: begin
        if (i_wr_rdy) begin
          rm_d      = rm_q & ~cur_onehot;
          th_done_d = cur_onehot;
          state_d   = (rm_d != 8'h00) ? ST_RD : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered: decide them from the state being entered.
    if (state_d == ST_RD) begin
      cur_d = lowest_idx(rm_d);
    end
    rd_req_d   = (state_d == ST_RD);
    wr_valid_d = (state_d == ST_WR);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      rm_q       <= 8'h00;
      cur_q      <= 3'd0;
      busy_q     <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 38'd0;
      wr_data_q  <= 32'd0;
      th_done_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rm_q       <= rm_d;
      cur_q      <= cur_d;
      busy_q     <= busy_d;
      rd_req_q   <= rd_req_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      th_done_q  <= th_done_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_rd_req   = rd_req_q;
  assign o_rd_th    = cur_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_th_done  = th_done_q;

endmodule

// File: tb/tb_vxe_vpu_stor_eu.sv
// ---------------------------------------------------------------------------
// tb_vxe_vpu_stor_eu
//
// Directed bench for the store execution unit. Cycle 0 is the cycle in which
// i_start is high. Inputs change 1 ns after the rising edge and outputs are
// sampled on the falling edge. A small register file model returns table data
// the cycle after each read request.
// ---------------------------------------------------------------------------
module tb_vxe_vpu_stor_eu;

  logic        clk;
  logic        nrst;
  logic        i_start;
  logic        o_busy;
  logic [7:0]  i_th_en;
  logic        o_rd_req;
  logic [2:0]  o_rd_th;
  logic [31:0] i_rd_data;
  logic [37:0] i_rd_addr;
  logic        o_wr_valid;
  logic [37:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        i_wr_rdy;
  logic [7:0]  o_th_done;

  vxe_vpu_stor_eu dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .i_th_en    (i_th_en),
    .o_rd_req   (o_rd_req),
    .o_rd_th    (o_rd_th),
    .i_rd_data  (i_rd_data),
    .i_rd_addr  (i_rd_addr),
    .o_wr_valid (o_wr_valid),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .i_wr_rdy   (i_wr_rdy),
    .o_th_done  (o_th_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Thread register file model: one-cycle read latency, poison otherwise.
  logic [31:0] mem_data [8];
  logic [37:0] mem_addr [8];
  logic        rd_vld_q;
  logic [2:0]  rd_idx_q;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= 3'd0;
    end else begin
      rd_vld_q <= o_rd_req;
      rd_idx_q <= o_rd_th;
    end
  end

  assign i_rd_data = rd_vld_q ? mem_data[rd_idx_q] : 32'hDEAD_BEEF;
  assign i_rd_addr = rd_vld_q ? mem_addr[rd_idx_q] : 38'h3F_DEAD_BEEF;

  int n_checks;
  int n_pass;

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-operation observation log
  logic [69:0] wr_log [$];
  int          wr_cyc [$];
  int          busy_first, busy_last, busy_cnt;
  int          rdreq_cnt, first_rd_th, done_cnt, done_bad, stall_viol;
  int          done_last_cyc;
  logic [7:0]  done_acc;
  logic        timed_out;

  task automatic run_op(input logic [7:0] en, input int stall,
                        input int s2_cyc, input logic [7:0] s2_en);
    int          stall_left;
    logic [69:0] hold;
    logic        hold_vld;
    wr_log.delete();
    wr_cyc.delete();
    busy_first = -1; busy_last = -1; busy_cnt = 0;
    rdreq_cnt = 0; first_rd_th = -1; done_cnt = 0; done_bad = 0;
    stall_viol = 0; done_last_cyc = -1; done_acc = 8'h00;
    timed_out = 1'b1;
    stall_left = stall;
    hold = '0;
    hold_vld = 1'b0;
    i_th_en = en;
    i_start = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (o_busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (o_rd_req) begin
        rdreq_cnt++;
        if (first_rd_th < 0) first_rd_th = int'(o_rd_th);
      end
      if (o_wr_valid) begin
        if (stall_left > 0) begin
          i_wr_rdy = 1'b0;
          stall_left--;
        end else begin
          i_wr_rdy = 1'b1;
        end
        if (hold_vld && ({o_wr_addr, o_wr_data} != hold)) stall_viol++;
        hold = {o_wr_addr, o_wr_data};
        hold_vld = !i_wr_rdy;
        if (i_wr_rdy) begin
          wr_log.push_back({o_wr_addr, o_wr_data});
          wr_cyc.push_back(cyc);
        end
      end else begin
        i_wr_rdy = 1'b1;
      end
      if (o_th_done != 8'h00) begin
        done_cnt++;
        done_acc |= o_th_done;
        done_last_cyc = cyc;
        if ($countones(o_th_done) != 1) done_bad++;
      end
      if (cyc >= 2 && !o_busy && cyc > busy_last + 1) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      i_start = (cyc + 1 == s2_cyc);
      i_th_en = i_start ? s2_en : en;
    end
    i_start = 1'b0;
    i_wr_rdy = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk_eq({pfx, "_busy"},     o_busy,     '0);
    chk_eq({pfx, "_rd_req"},   o_rd_req,   '0);
    chk_eq({pfx, "_rd_th"},    o_rd_th,    '0);
    chk_eq({pfx, "_wr_valid"}, o_wr_valid, '0);
    chk_eq({pfx, "_wr_addr"},  o_wr_addr,  '0);
    chk_eq({pfx, "_wr_data"},  o_wr_data,  '0);
    chk_eq({pfx, "_th_done"},  o_th_done,  '0);
  endtask

  initial begin
    int          wv_seen;
    int          act;
    logic [37:0] base;
    n_checks = 0;
    n_pass   = 0;
    base     = 38'h00_0000_1000;
    for (int i = 0; i < 8; i++) begin
      mem_data[i] = 32'(i);
      mem_addr[i] = base + 38'(i);
    end
    nrst     = 1'b0;
    i_start  = 1'b0;
    i_th_en  = 8'h00;
    i_wr_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Single thread 2
    mem_data[2] = 32'h3F80_0000;
    mem_addr[2] = 38'h100;
    run_op(8'h04, 0, -1, 8'h00);
    chk_eq("t1_timeout", timed_out, 1'b0);
    chk_eq("t1_rd_th", first_rd_th, 2);
    chk_eq("t1_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk_eq("t1_wr", wr_log[0], {38'h100, 32'h3F80_0000});
      chk_eq("t1_wr_cyc", wr_cyc[0], 3);
    end
    chk_eq("t1_done", done_acc, 8'h04);
    chk_eq("t1_done_cyc", done_last_cyc, 4);
    chk_eq("t1_busy_span", {busy_first, busy_last, busy_cnt}, {32'd1, 32'd3, 32'd3});
    mem_data[2] = 32'd2;
    mem_addr[2] = base + 38'd2;

    // All threads
    run_op(8'hFF, 0, -1, 8'h00);
    chk_eq("t2_timeout", timed_out, 1'b0);
    chk_eq("t2_nwr", wr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      chk_eq($sformatf("t2_wr%0d", i), wr_log[i], {base + 38'(i), 32'(i)});
      chk_eq($sformatf("t2_wr%0d_cyc", i), wr_cyc[i], 3 * i + 3);
    end
    chk_eq("t2_rdreq", rdreq_cnt, 8);
    chk_eq("t2_done", {done_acc, 8'(done_cnt), 8'(done_bad)}, {8'hFF, 8'd8, 8'd0});
    chk_eq("t2_done_cyc", done_last_cyc, 25);
    chk_eq("t2_busy_span", {busy_first, busy_last, busy_cnt}, {32'd1, 32'd24, 32'd24});

    // Empty mask
    run_op(8'h00, 0, -1, 8'h00);
    chk_eq("t3_timeout", timed_out, 1'b0);
    chk_eq("t3_busy_span", {busy_first, busy_last, busy_cnt}, {32'd1, 32'd1, 32'd1});
    chk_eq("t3_activity", {32'(rdreq_cnt), 32'(wr_log.size()), 32'(done_cnt)}, '0);

    // Back-pressure on the first write
    run_op(8'h81, 5, -1, 8'h00);
    chk_eq("t4_timeout", timed_out, 1'b0);
    chk_eq("t4_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk_eq("t4_wr0", wr_log[0], {base, 32'd0});
      chk_eq("t4_wr1", wr_log[1], {base + 38'd7, 32'd7});
      chk_eq("t4_wr0_cyc", wr_cyc[0], 8);
    end
    chk_eq("t4_stable", stall_viol, 0);
    chk_eq("t4_busy_cnt", busy_cnt, 11);
    chk_eq("t4_done", done_acc, 8'h81);

    // Start while busy is ignored
    run_op(8'h03, 0, 2, 8'hF0);
    chk_eq("t5_timeout", timed_out, 1'b0);
    chk_eq("t5_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk_eq("t5_wr0", wr_log[0], {base, 32'd0});
      chk_eq("t5_wr1", wr_log[1], {base + 38'd1, 32'd1});
    end
    chk_eq("t5_busy_span", {busy_first, busy_last, busy_cnt}, {32'd1, 32'd6, 32'd6});
    chk_eq("t5_done", done_acc, 8'h03);

    // Reset in the middle of the third write
    i_th_en = 8'hFF;
    i_start = 1'b1;
    wv_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_wr_valid) wv_seen++;
      if (wv_seen == 3) break;
      @(posedge clk);
      #1;
      i_start = 1'b0;
    end
    i_start = 1'b0;
    chk_eq("t6_reached_wr3", wv_seen, 3);
    nrst = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    act = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (o_busy || o_rd_req || o_wr_valid || (o_th_done != 8'h00)) act++;
    end
    chk_eq("t6_idle_after", act, 0);
    @(posedge clk);
    #1;
    run_op(8'h01, 0, -1, 8'h00);
    chk_eq("t6_timeout", timed_out, 1'b0);
    chk_eq("t6_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk_eq("t6_wr0", wr_log[0], {base, 32'd0});
    end
    chk_eq("t6_busy_cnt", busy_cnt, 3);
    chk_eq("t6_done", done_acc, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vxe_vpu_stor_eu.md
# vxe_vpu_stor_eu

Store execution unit of the VxE vector processing unit, sitting on the execution side of the store ECU. It accepts a one-cycle start strobe, drives busy for the whole operation and walks the enabled threads in ascending order. For each thread it reads the result and destination address from the thread register file, then issues one 32-bit write request to the memory request interface. Busy falls once the last write has been accepted.

## Interface
- Parameters: none; all widths fixed (8 threads, 32-bit data, 38-bit word address).
- clk  in  1  clock; all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- i_start  in  1  start strobe from the store ECU; one cycle.
- o_busy  out  1  operation in progress; registered.
- i_th_en  in  8  thread enable mask; sampled only on accepted start.
- o_rd_req  out  1  thread register file read request.
- o_rd_th  out  3  thread index being read.
- i_rd_data  in  32  thread result; valid the cycle after o_rd_req.
- i_rd_addr  in  38  thread destination word address; valid the cycle after o_rd_req.
- o_wr_valid  out  1  write request valid.
- o_wr_addr  out  38  write word address.
- o_wr_data  out  32  write data.
- i_wr_rdy  in  1  write request accepted when high together with o_wr_valid.
- o_th_done  out  8  one-cycle per-thread "stored" pulse; one-hot or zero.

## Operation
- States: IDLE, RD, CAP, WR, NOP.
- o_busy = (state != IDLE), registered.
- **IDLE**
  - On i_start, latch i_th_en into a remaining mask rm.
  - rm != 0 -> RD; rm == 0 -> NOP.
  - i_start in any other state is ignored; rm is unchanged.
- **NOP**
  - Issues nothing; -> IDLE. Busy is high for exactly one cycle.
- **RD**
  - Drives o_rd_req=1 and o_rd_th = index of the lowest set bit of rm; latches that index as cur.
  - -> CAP.
- **CAP**
  - Captures i_rd_data and i_rd_addr into the write registers.
  - -> WR.
- **WR**
  - Drives o_wr_valid=1; o_wr_addr and o_wr_data stay stable until accepted.
  - On i_wr_rdy: clear rm[cur] and pulse o_th_done[cur] in the next cycle.
  - After acceptance: next state is RD if the updated rm != 0, else IDLE.
  - Without i_wr_rdy: stay in WR; no timeout.
- Threads are served strictly in ascending index order. Exactly one write is issued per enabled thread, and no duplicate writes occur.
- Reset, including mid-operation:
  - All state is cleared; an outstanding write is dropped.
  - Outputs: o_busy=0, o_rd_req=0, o_rd_th=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_th_done=0; state=IDLE; rm=0.

## Timing
- Start accepted at cycle 0, so o_busy=1 from cycle 1.
- Per thread with i_wr_rdy held high:
  - RD at cycle n.
  - CAP at n+1.
  - WR at n+2, accepted at n+2.
  - Next RD at n+3; 3 cycles per thread.
- k enabled threads, no back-pressure: busy cycles 1..3k; o_busy=0 at cycle 3k+1.
- Final o_th_done pulse coincides with the first cycle of o_busy=0.
- Each WR cycle with i_wr_rdy=0 adds one cycle to the total.
- Empty mask: busy only in cycle 1.
- A new start is accepted in the first IDLE cycle, i.e. the first cycle o_busy=0.
- o_rd_req is high only in RD. o_wr_valid is high only in WR.

## Test plan
- **Single thread.** i_th_en=8'h04, rd returns data 32'h3F800000, addr 38'h100, rdy=1 -> rd_th=2 in cycle 1; write (38'h100, 32'h3F800000) in cycle 3; o_th_done=8'h04 in cycle 4; busy cycles 1-3 only.
- **All threads.** i_th_en=8'hFF, data=thread index, rdy=1 -> 8 writes in order th0..th7; busy cycles 1-24; low at 25.
- **Empty mask.** i_th_en=8'h00 -> busy high in cycle 1 only; no rd_req, wr_valid or th_done activity.
- **Back-pressure.** i_th_en=8'h81, i_wr_rdy low 5 cycles on the first write -> addr/data held stable; th0 then th7 written; busy lasts 11 cycles.
- **Start while busy.** i_th_en=8'h03, second i_start with 8'hF0 at cycle 2 -> ignored; only th0 and th1 written; busy cycles 1-6.
- **Reset mid-operation.** i_th_en=8'hFF, nrst low during the third WR -> all outputs 0 immediately; after release, idle until the next start; a fresh start with 8'h01 performs exactly one write.
